// File: rtl/led_pkg.sv
// Shared types and constants for the LED blink-path sequencer.
package led_pkg;

  // Sequencer states. The encoding is kept small and stable so that a checker
  // bound to the state register can compare against these names.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLASH = 2'd2
  } state_t;

  // Bit positions inside the synchronised switch word.
  localparam int SW_RUN  = 0;
  localparam int SW_MODE = 1;
  localparam int SW_DIR  = 2;
  localparam int SW_RAMP = 3;

  // Meaning of the mode switch.
  localparam logic MODE_SHIFT = 1'b0;
  localparam logic MODE_FLASH = 1'b1;

  // Meaning of the direction switch.
  localparam logic DIR_TO_MSB = 1'b0;
  localparam logic DIR_TO_LSB = 1'b1;

  // Width of the blink-rate counter period select.
  localparam int PSEL_W = 2;

  // Running state selected by the mode switch.
  function automatic state_t mode_state(input logic mode);
    return (mode == MODE_FLASH) ? FLASH : SHIFT;
  endfunction

endpackage

// File: rtl/sw_sync.sv
// Two-flop synchroniser for a bus of slow, independent switch inputs.
// Each bit is synchronised on its own; no coherency between bits is implied.
module sw_sync #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First stage may go metastable; second stage gives the settled value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED blink-path sequencer: synchronises the user switches, drives the
// blink-rate counter enable/period select, and steps a shift-chase or flash
// pattern once per counter tick. Each completed sweep can ramp the counter
// to the next faster period.
//
// Handshake: i_tick is a single-cycle strobe with no back-pressure; every
// cycle it is high while running (and not pre-empted by a run drop or a
// mode change) produces exactly one pattern update on that clock edge.
//
// NB_LEDS must be at least 2; NB_SW is fixed at 4 by the switch bit map.
module led_sequencer
  import led_pkg::*;
#(
  parameter int NB_LEDS = 4,
  parameter int NB_SW   = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic               i_tick,
  output logic [NB_LEDS-1:0] o_led,
  output logic               o_count_en,
  output logic [PSEL_W-1:0]  o_period_sel
);

  localparam int STEP_W = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NB_LEDS - 1);

  logic [NB_SW-1:0]  sw_s;
  state_t            state;
  logic [STEP_W-1:0] step;

  // First pattern shown when a running state is entered.
  function automatic logic [NB_LEDS-1:0] start_pattern(input logic mode,
                                                       input logic dir);
    logic [NB_LEDS-1:0] p;
    if (mode == MODE_FLASH) begin
      p = '1;
    end else if (dir == DIR_TO_LSB) begin
      p = {1'b1, {(NB_LEDS-1){1'b0}}};
    end else begin
      p = {{(NB_LEDS-1){1'b0}}, 1'b1};
    end
    return p;
  endfunction

  // One-position rotation with wrap-around at both ends.
  function automatic logic [NB_LEDS-1:0] rotate(input logic [NB_LEDS-1:0] v,
                                                input logic dir);
    logic [NB_LEDS-1:0] r;
    if (dir == DIR_TO_LSB) begin
      r = {v[0], v[NB_LEDS-1:1]};
    end else begin
      r = {v[NB_LEDS-2:0], v[NB_LEDS-1]};
    end
    return r;
  endfunction

  sw_sync #(
    .W (NB_SW)
  ) u_sw_sync (
    .clock   (clock),
    .reset_n (i_reset),
    .d       (i_sw),
    .q       (sw_s)
  );

  // Sequencer FSM with registered LED, counter-enable and period outputs.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= IDLE;
      o_led        <= '0;
      o_count_en   <= 1'b0;
      o_period_sel <= '0;
      step         <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_led        <= '0;
          o_count_en   <= 1'b0;
          o_period_sel <= '0;
          step         <= '0;
          if (sw_s[SW_RUN]) begin
            state      <= mode_state(sw_s[SW_MODE]);
            o_led      <= start_pattern(sw_s[SW_MODE], sw_s[SW_DIR]);
            o_count_en <= 1'b1;
          end
        end

        SHIFT, FLASH: begin
          if (!sw_s[SW_RUN]) begin
            // Run drop wins over any tick on the same edge.
            state        <= IDLE;
            o_led        <= '0;
            o_count_en   <= 1'b0;
            o_period_sel <= '0;
            step         <= '0;
          end else if (i_tick) begin
            if (mode_state(sw_s[SW_MODE]) != state) begin
              // Mode change replaces the advance; the period is kept.
              state <= mode_state(sw_s[SW_MODE]);
              o_led <= start_pattern(sw_s[SW_MODE], sw_s[SW_DIR]);
              step  <= '0;
            end else begin
              o_led <= (state == FLASH) ? ~o_led : rotate(o_led, sw_s[SW_DIR]);
              if (step == STEP_LAST) begin
                // Sweep complete: the counter has just self-cleared, so the
                // period can move without overshooting the new threshold.
                step <= '0;
                if (sw_s[SW_RAMP]) begin
                  o_period_sel <= o_period_sel + PSEL_W'(1);
                end
              end else begin
                step <= step + STEP_W'(1);
              end
            end
          end
        end

        default: begin
          state        <= IDLE;
          o_led        <= '0;
          o_count_en   <= 1'b0;
          o_period_sel <= '0;
          step         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with NB_LEDS = 4.
module tb_led_sequencer;
  import led_pkg::*;

  localparam int NB_LEDS = 4;
  localparam int NB_SW   = 4;

  logic               clock;
  logic               i_reset;
  logic [NB_SW-1:0]   i_sw;
  logic               i_tick;
  logic [NB_LEDS-1:0] o_led;
  logic               o_count_en;
  logic [1:0]         o_period_sel;

  int n_checks = 0;
  int n_errors = 0;

  logic [NB_LEDS-1:0] exp_q[$];

  led_sequencer #(
    .NB_LEDS (NB_LEDS),
    .NB_SW   (NB_SW)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_sw         (i_sw),
    .i_tick       (i_tick),
    .o_led        (o_led),
    .o_count_en   (o_count_en),
    .o_period_sel (o_period_sel)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks: inputs change on the falling edge, outputs are sampled there.
  task automatic step_clk();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_tick();
    i_tick = 1'b1;
    step_clk();
    i_tick = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_led"},  32'(o_led),        32'h0);
    check({tag, "_en"},   32'(o_count_en),   32'h0);
    check({tag, "_psel"}, 32'(o_period_sel), 32'h0);
  endtask

  initial begin
    i_reset = 1'b0;
    i_sw    = '0;
    i_tick  = 1'b0;

    // 1. Reset and idle behaviour
    repeat (2) @(negedge clock);
    check_idle("reset");
    check("reset_state", 32'(dut.state), 32'(IDLE));
    i_reset = 1'b1;
    repeat (3) do_tick();
    check_idle("idle_ticks");

    // 2. Shift toward MSB with ramp
    i_sw = 4'b1001;
    step_clk();
    step_clk();
    check("start_lat_en", 32'(o_count_en), 32'h0);
    step_clk();
    check("start_en",  32'(o_count_en), 32'h1);
    check("start_led", 32'(o_led),      32'b0001);
    exp_q = {4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 1; i <= 4; i++) begin
      do_tick();
      check("shift_up_led", 32'(o_led), 32'(exp_q.pop_front()));
      if (i == 3) check("psel_before_wrap", 32'(o_period_sel), 32'h0);
    end
    check("psel_after_sweep", 32'(o_period_sel), 32'h1);
    check("step_wrapped",     32'(dut.step),     32'h0);
    for (int i = 1; i <= 12; i++) begin
      do_tick();
      if (i % 4 == 0) check("psel_ramp", 32'(o_period_sel), 32'((1 + i / 4) % 4));
    end
    check("ramp_led", 32'(o_led), 32'b0001);
    repeat (4) do_tick();
    check("psel_again", 32'(o_period_sel), 32'h1);

    // Stop then back-to-back restart in the other direction, no ramp
    i_sw = 4'b0000;
    repeat (3) step_clk();
    check_idle("stop");
    i_sw = 4'b0101;
    repeat (3) step_clk();
    check("dir_start_led", 32'(o_led),        32'b1000);
    check("dir_start_psel", 32'(o_period_sel), 32'h0);

    // 3. Direction toward LSB
    exp_q = {4'b0100, 4'b0010, 4'b0001, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      do_tick();
      check("shift_dn_led", 32'(o_led), 32'(exp_q.pop_front()));
    end
    check("no_ramp_psel", 32'(o_period_sel), 32'h0);

    // Direction flip mid-run: no reload, next rotation goes the new way
    i_sw = 4'b0001;
    step_clk();
    step_clk();
    check("dir_flip_hold", 32'(o_led), 32'b1000);
    do_tick();
    check("dir_flip_led", 32'(o_led), 32'b0001);

    // 4. Flash with ramp, then mode switch back to shift
    i_sw = 4'b0000;
    repeat (3) step_clk();
    check_idle("stop2");
    i_sw = 4'b1011;
    repeat (3) step_clk();
    check("flash_start", 32'(o_led), 32'b1111);
    check("flash_state", 32'(dut.state), 32'(FLASH));
    do_tick();
    check("flash_t1", 32'(o_led), 32'b0000);
    do_tick();
    check("flash_t2", 32'(o_led), 32'b1111);
    do_tick();
    do_tick();
    check("flash_t4",   32'(o_led),        32'b1111);
    check("flash_psel", 32'(o_period_sel), 32'h1);
    do_tick();
    check("flash_step", 32'(dut.step), 32'h1);
    i_sw = 4'b1001;
    step_clk();
    step_clk();
    check("mode_wait_led", 32'(o_led), 32'b0000);
    do_tick();
    check("mode_sw_led",   32'(o_led),        32'b0001);
    check("mode_sw_state", 32'(dut.state),    32'(SHIFT));
    check("mode_sw_step",  32'(dut.step),     32'h0);
    check("mode_sw_psel",  32'(o_period_sel), 32'h1);
    do_tick();
    check("after_mode_led", 32'(o_led), 32'b0010);

    // 5. Run drop coinciding with a tick
    i_sw = 4'b1000;
    step_clk();
    step_clk();
    check("drop_hold_led", 32'(o_led), 32'b0010);
    do_tick();
    check_idle("drop_tick");
    check("drop_state", 32'(dut.state), 32'(IDLE));

    // 6. Glitches on run
    i_sw = 4'b0000;
    #1 i_sw = 4'b0001;
    #2 i_sw = 4'b0000;
    repeat (4) step_clk();
    check_idle("glitch_missed");
    i_sw = 4'b0001;
    step_clk();
    i_sw = 4'b0000;
    step_clk();
    step_clk();
    check("glitch_start_en",  32'(o_count_en), 32'h1);
    check("glitch_start_led", 32'(o_led),      32'b0001);
    step_clk();
    check_idle("glitch_stop");

    // Reset mid-run: immediate clear, restart needs run resynchronised
    i_sw = 4'b0001;
    repeat (3) step_clk();
    do_tick();
    check("pre_reset_led", 32'(o_led), 32'b0010);
    #1 i_reset = 1'b0;
    #1;
    check_idle("async_reset");
    @(negedge clock);
    i_reset = 1'b1;
    step_clk();
    step_clk();
    check("restart_lat_en", 32'(o_count_en), 32'h0);
    step_clk();
    check("restart_en",  32'(o_count_en), 32'h1);
    check("restart_led", 32'(o_led),      32'b0001);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Sequencer for the LED blink path. Synchronises the user switches, enables and configures the blink-rate counter (enable plus 2-bit period select), and advances an LED pattern once per one-cycle tick from that counter. Runs a shift-chase or a flash pattern, and after every completed sweep steps the counter to the next faster period.

## Interface
- `NB_LEDS`, default 4: LED count; must be ≥ 2.
- `NB_SW`, default 4: switch count; fixed at 4 by the bit map below.
- `clock`  in  1: sole clock.
- `i_reset`  in  1: asynchronous, active-low reset.
- `i_sw`  in  NB_SW: raw switches.
  - `[0]` run.
  - `[1]` mode: 0 = shift, 1 = flash.
  - `[2]` direction: 0 = toward MSB, 1 = toward LSB.
  - `[3]` ramp enable.
- `i_tick`  in  1: one-cycle pulse from the blink-rate counter.
- `o_led`  out  NB_LEDS: LED drive, registered.
- `o_count_en`  out  1: counter enable, registered.
- `o_period_sel`  out  2: counter period select (0 = slowest, 3 = fastest), registered.

## Operation
- **Switch synchronisation**
  - `i_sw` passes through a 2-flop synchroniser to give `sw_s`.
  - Only `sw_s` is used internally.
  - Latency from a switch change to `sw_s` is 2 cycles.
- **Internal state**
  - FSM states: IDLE, SHIFT, FLASH.
  - `step`: counter of width clog2(NB_LEDS).
- **IDLE**
  - Outputs: `o_led`=0, `o_count_en`=0, `o_period_sel`=0, `step`=0.
  - `i_tick` is ignored.
  - If `sw_s[0]`=1:
    - Go to SHIFT when `sw_s[1]`=0, or FLASH when `sw_s[1]`=1.
    - Load the start pattern and set `o_count_en`=1.
- **Start patterns**
  - SHIFT: one-hot, bit 0 when dir=0, bit NB_LEDS-1 when dir=1.
  - FLASH: all ones.
- **SHIFT, on `i_tick`:** rotate `o_led` by one position in the current `sw_s[2]` direction. Rotation wraps MSB→bit 0 and bit 0→MSB.
- **FLASH, on `i_tick`:** `o_led` ← ~`o_led`.
- **Sweep accounting (both running states, on each `i_tick`)**
  - `step` increments.
  - When `step`==NB_LEDS-1, `step` wraps to 0.
  - At that wrap, if `sw_s[3]`=1, `o_period_sel` increments modulo 4 (3→0). If `sw_s[3]`=0, `o_period_sel` holds.
- **Mode change while running**
  - Sampled only on `i_tick`.
  - If `sw_s[1]` disagrees with the current state, switch state on that tick instead of advancing.
  - Load the new start pattern and set `step`=0. `o_period_sel` is kept.
- **Direction change:** takes effect at the next rotation; no reload.
- **Run drop:** `sw_s[0]`=0 in any running state goes to IDLE on the next edge, regardless of `i_tick`. All outputs take their IDLE values.
- **Priority:** reset > run drop > mode change > pattern advance.

## Timing
- **Reset (asynchronous assert):**
  - State IDLE, `o_led`=0, `o_count_en`=0, `o_period_sel`=0, `step`=0.
  - Synchroniser flops cleared.
  - Release is synchronous to `clock`.
- **Start:** `i_sw[0]` rises at edge N → `o_count_en` and the start pattern appear after edge N+3 (2 sync + 1 FSM).
- **Pattern latency:** `i_tick` high at edge T → new `o_led` visible after T. One update per tick.
- **Period select update:**
  - `o_period_sel` changes after the tick edge on which the counter self-clears.
  - The counter therefore compares its new threshold starting from a count of 0 or 1, so no overshoot occurs.
- **Tick with run drop:** `i_tick` coincident with `sw_s[0]`=0 is discarded. The result is IDLE with no advance.
- **Stop/restart:** back-to-back stop/start restarts from the start pattern with `o_period_sel`=0.
- **Reset mid-run:** returns to reset values immediately. Restart needs `sw_s[0]`=1 again after release.

## Structure
- **Package `led_pkg`:**
  - State enum: IDLE/SHIFT/FLASH.
  - Switch bit indices: RUN=0, MODE=1, DIR=2, RAMP=3.
  - Mode encodings.
  - Period select width (2).
- **Sub-module `sw_sync`:** parameterised-width 2-flop synchroniser with async active-low clear; one instance on `i_sw`.
- **Top level:** FSM, rotate/invert datapath, and `step`/`o_period_sel` counters live in `led_sequencer`.

## Test plan
Directed scenarios, all with NB_LEDS=4:
1. **Reset:** assert `i_reset`=0 mid-cycle → all outputs 0 immediately. Release and hold `i_sw`=0 → outputs stay 0 and ticks are ignored.
2. **Shift with ramp:** `i_sw`=4'b1001 → `o_count_en`=1 and `o_led`=0001 after 3 cycles.
   - 4 ticks → `o_led` 0010, 0100, 1000, 0001.
   - `o_period_sel` becomes 1 after the 4th tick.
   - 12 more ticks → `o_period_sel`=0 (wrap).
3. **Direction:** `i_sw`=4'b0101 → start at 1000. Ticks → 0100, 0010, 0001, 1000. `o_period_sel` stays 0 (ramp off).
4. **Flash and mode switch:** `i_sw`=4'b0011 → 1111, then 0000 and 1111 on successive ticks. Set mode=0 → on the next tick `o_led`=0001, `step`=0, `o_period_sel` unchanged.
5. **Run drop with tick:** while in SHIFT, drop `sw[0]` so `sw_s[0]`=0 coincides with `i_tick` → next edge IDLE, `o_led`=0, `o_count_en`=0, `o_period_sel`=0.
6. **Glitch:** 1-cycle pulse on `i_sw[0]` aligned between edges → `sw_s` captures it or not. If captured, one start then stop, with no X and no stuck state.
